// File: rtl/pm_stream_adapter.sv
// pm_stream_adapter: loads four N-bit operands from a W-bit stream, starts the point-multiply core,
// and streams the (x, y) result back out. Optional WAIT watchdog: define PM_ADAPTER_TIMEOUT_EN.
module pm_stream_adapter #(
  parameter int N = 233,
  parameter int W = 32,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         m_last,
  output logic [N-1:0] PM_DIN_P_x,
  output logic [N-1:0] PM_DIN_P_y,
  output logic [N-1:0] PM_random_z,
  output logic [N-1:0] PM_key,
  output logic         PM_IN_VALID,
  input  logic [N-1:0] PM_DOUT_x,
  input  logic [N-1:0] PM_DOUT_y,
  input  logic         PM_OUT_VALID,
  output logic         busy,
  output logic         timeout
);
  localparam int WORDS = (N + W - 1) / W;
  localparam int PAD = WORDS * W - N;
  localparam int WB = $clog2(WORDS);
  localparam int IW = WB + 2;
  localparam int OW = WB + 1;
  typedef enum logic [1:0] {LOAD, FIRE, WAIT, SEND} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] in_cnt_q, in_cnt_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic [N-1:0] x_q, x_d, y_q, y_d, z_q, z_d, k_q, k_d, rx_q, rx_d, ry_q, ry_d;
  logic prev_q;
  logic wr, edge_seen, tmo_hit;
  logic [1:0] sel;
  logic [WB-1:0] wi;
  logic [2*WORDS*W-1:0] out_vec;
  // Drop word d into slot i of an operand; bits beyond N fall off on truncation.
  function automatic logic [N-1:0] put(input logic [N-1:0] v, input logic [WB-1:0] i, input logic [W-1:0] d);
    logic [WORDS*W-1:0] t;
    t = {{PAD{1'b0}}, v};
    t[i*W +: W] = d;
    return t[N-1:0];
  endfunction
  assign s_ready = state_q == LOAD;
  assign PM_IN_VALID = state_q == FIRE;
  assign m_valid = state_q == SEND;
  assign busy = state_q != LOAD;
  assign m_last = m_valid && (&out_cnt_q);
  assign wr = s_valid && s_ready;
  assign sel = in_cnt_q[IW-1 -: 2];
  assign wi = in_cnt_q[WB-1:0];
  // Only a fresh rising edge counts, so a level held over from the last result is ignored.
  assign edge_seen = PM_OUT_VALID && !prev_q;
  assign out_vec = {{PAD{1'b0}}, ry_q, {PAD{1'b0}}, rx_q};
  assign m_data = out_vec[out_cnt_q*W +: W];
  assign PM_DIN_P_x = x_q;
  assign PM_DIN_P_y = y_q;
  assign PM_random_z = z_q;
  assign PM_key = k_q;
  always_comb begin
    state_d = state_q;
    in_cnt_d = wr ? in_cnt_q + 1'b1 : in_cnt_q;
    out_cnt_d = (m_valid && m_ready) ? out_cnt_q + 1'b1 : out_cnt_q;
    x_d = (wr && sel == 2'd0) ? put(x_q, wi, s_data) : x_q;
    y_d = (wr && sel == 2'd1) ? put(y_q, wi, s_data) : y_q;
    z_d = (wr && sel == 2'd2) ? put(z_q, wi, s_data) : z_q;
    k_d = (wr && sel == 2'd3) ? put(k_q, wi, s_data) : k_q;
    rx_d = rx_q;
    ry_d = ry_q;
    case (state_q)
      LOAD: state_d = (wr && (&in_cnt_q)) ? FIRE : LOAD;
      FIRE: state_d = WAIT;
      WAIT: begin
        if (edge_seen) begin
          rx_d = PM_DOUT_x;
          ry_d = PM_DOUT_y;
          state_d = SEND;
        end else if (tmo_hit) begin
          rx_d = '0;
          ry_d = '0;
          state_d = SEND;
        end
      end
      SEND: state_d = (m_ready && (&out_cnt_q)) ? LOAD : SEND;
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= LOAD;
      in_cnt_q <= '0;
      out_cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      k_q <= '0;
      rx_q <= '0;
      ry_q <= '0;
      prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_cnt_q <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      k_q <= k_d;
      rx_q <= rx_d;
      ry_q <= ry_d;
      prev_q <= PM_OUT_VALID;
    end
  end
`ifdef PM_ADAPTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic tmo_q, tmo_d;
  assign tmo_hit = tcnt_q == TW'(TIMEOUT_CYCLES - 1);
  assign timeout = tmo_q;
  assign tcnt_d = (state_q == WAIT) ? tcnt_q + 1'b1 : '0;
  assign tmo_d = (state_q == FIRE) ? 1'b0 : (state_q == WAIT && !edge_seen && tmo_hit) ? 1'b1 : tmo_q;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tcnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_pm_stream_adapter.sv
// tb_pm_stream_adapter: directed frame table plus hand-written held-level, reset and timeout sequences.
module tb_pm_stream_adapter;
  logic CLK = 1'b0, RST_N = 1'b0, s_valid = 1'b0, m_ready = 1'b0, PM_OUT_VALID = 1'b0;
  logic [31:0] s_data = '0;
  logic [232:0] PM_DOUT_x = '0, PM_DOUT_y = '0;
  logic s_ready, m_valid, m_last, PM_IN_VALID, busy, timeout;
  logic [31:0] m_data;
  logic [232:0] PM_DIN_P_x, PM_DIN_P_y, PM_random_z, PM_key;
  int npass = 0, ntot = 0, fire_cnt = 0, base;
  typedef struct {
    logic [31:0] x0, y0, z0, k0, w7;
    logic [8:0]  top;
    logic [31:0] rx0, ry0;
    logic [8:0]  rtop;
    logic [31:0] m7;
  } vec_t;
  vec_t tv [4];
  pm_stream_adapter #(.N(233), .W(32), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .PM_DIN_P_x(PM_DIN_P_x), .PM_DIN_P_y(PM_DIN_P_y), .PM_random_z(PM_random_z), .PM_key(PM_key),
    .PM_IN_VALID(PM_IN_VALID), .PM_DOUT_x(PM_DOUT_x), .PM_DOUT_y(PM_DOUT_y),
    .PM_OUT_VALID(PM_OUT_VALID), .busy(busy), .timeout(timeout)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) if (PM_IN_VALID) fire_cnt++;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
  task automatic tally(input string nm, input bit ok, input string got, input string want);
    ntot++;
    if (ok) npass++;
    else $display("FAIL %s: got %s, expected %s", nm, got, want);
  endtask
  task automatic chk_b(input string nm, input logic a, input logic e);
    tally(nm, a === e, $sformatf("%b", a), $sformatf("%b", e));
  endtask
  task automatic chk_w(input string nm, input logic [31:0] a, input logic [31:0] e);
    tally(nm, a === e, $sformatf("%h", a), $sformatf("%h", e));
  endtask
  task automatic chk_n(input string nm, input logic [232:0] a, input logic [232:0] e);
    tally(nm, a === e, $sformatf("%h", a), $sformatf("%h", e));
  endtask
  task automatic chk_i(input string nm, input int a, input int e);
    tally(nm, a == e, $sformatf("%0d", a), $sformatf("%0d", e));
  endtask
  function automatic logic [232:0] opv(input logic [31:0] w0, input logic [8:0] top);
    return {top, 192'd0, w0};
  endfunction
  function automatic logic [511:0] outv(input logic [31:0] w0, w7, w8, w15);
    logic [511:0] e;
    e = '0;
    e[31:0] = w0;
    e[7*32 +: 32] = w7;
    e[8*32 +: 32] = w8;
    e[15*32 +: 32] = w15;
    return e;
  endfunction
  task automatic load(input logic [31:0] x0, y0, z0, k0, w7, input int nw);
    for (int i = 0; i < nw; i++) begin
      logic [31:0] v0;
      v0 = (i / 8 == 0) ? x0 : (i / 8 == 1) ? y0 : (i / 8 == 2) ? z0 : k0;
      s_valid = 1'b1;
      s_data = (i % 8 == 0) ? v0 : (i % 8 == 7) ? w7 : 32'd0;
      @(negedge CLK);
    end
    s_valid = 1'b0;
    s_data = '0;
  endtask
  task automatic pulse(input logic [232:0] rx, input logic [232:0] ry);
    PM_DOUT_x = rx;
    PM_DOUT_y = ry;
    PM_OUT_VALID = 1'b1;
    @(negedge CLK);
    PM_OUT_VALID = 1'b0;
  endtask
  task automatic drain(input logic [511:0] e);
    for (int j = 0; j < 16; j++) begin
      int s;
      s = $urandom_range(0, 2);
      m_ready = 1'b0;
      repeat (s) begin
        chk_w("m_data_stall", m_data, e[j*32 +: 32]);
        chk_b("m_last_stall", m_last, j == 15);
        @(negedge CLK);
      end
      m_ready = 1'b1;
      chk_b("m_valid", m_valid, 1'b1);
      chk_w("m_data", m_data, e[j*32 +: 32]);
      chk_b("m_last", m_last, j == 15);
      @(negedge CLK);
    end
    m_ready = 1'b0;
  endtask
  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask
  initial begin
    tv[0] = '{x0: 32'h1, y0: 32'h2, z0: 32'h3, k0: 32'h5, w7: 32'h0, top: 9'h000,
              rx0: 32'hABC, ry0: 32'h123, rtop: 9'h000, m7: 32'h0};
    tv[1] = '{x0: 32'hDEADBEEF, y0: 32'h0000FFFF, z0: 32'h80000001, k0: 32'h12345678, w7: 32'hFFFFFFFF,
              top: 9'h1FF, rx0: 32'hFFFFFFFF, ry0: 32'h55AA55AA, rtop: 9'h1FF, m7: 32'h1FF};
    tv[2] = '{x0: 32'h11, y0: 32'h22, z0: 32'h33, k0: 32'h44, w7: 32'hFFFFFE00, top: 9'h000,
              rx0: 32'h0, ry0: 32'hCAFEF00D, rtop: 9'h0A5, m7: 32'hA5};
    tv[3] = '{x0: 32'hA5A5A5A5, y0: 32'h5A5A5A5A, z0: 32'h0, k0: 32'hFFFFFFFF, w7: 32'h12345755,
              top: 9'h155, rx0: 32'h1, ry0: 32'h2, rtop: 9'h100, m7: 32'h100};
    do_reset();
    chk_b("rst_s_ready", s_ready, 1'b1);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_m_valid", m_valid, 1'b0);
    chk_b("rst_m_last", m_last, 1'b0);
    chk_b("rst_in_valid", PM_IN_VALID, 1'b0);
    chk_b("rst_timeout", timeout, 1'b0);
    chk_n("rst_x", PM_DIN_P_x, '0);
    chk_n("rst_key", PM_key, '0);
    for (int v = 0; v < 4; v++) begin
      base = fire_cnt;
      load(tv[v].x0, tv[v].y0, tv[v].z0, tv[v].k0, tv[v].w7, 32);
      chk_b("fire_pulse", PM_IN_VALID, 1'b1);
      chk_b("fire_s_ready", s_ready, 1'b0);
      chk_n("op_x", PM_DIN_P_x, opv(tv[v].x0, tv[v].top));
      chk_n("op_y", PM_DIN_P_y, opv(tv[v].y0, tv[v].top));
      chk_n("op_z", PM_random_z, opv(tv[v].z0, tv[v].top));
      chk_n("op_key", PM_key, opv(tv[v].k0, tv[v].top));
      @(negedge CLK);
      chk_b("fire_once", PM_IN_VALID, 1'b0);
      chk_b("wait_busy", busy, 1'b1);
      chk_b("wait_s_ready", s_ready, 1'b0);
      @(negedge CLK);
      chk_i("fire_count", fire_cnt - base, 1);
      chk_b("wait_no_m_valid", m_valid, 1'b0);
      pulse(opv(tv[v].rx0, tv[v].rtop), opv(tv[v].ry0, tv[v].rtop));
      chk_b("timeout_normal", timeout, 1'b0);
      drain(outv(tv[v].rx0, tv[v].m7, tv[v].ry0, tv[v].m7));
      chk_b("back_s_ready", s_ready, 1'b1);
      chk_b("back_busy", busy, 1'b0);
      chk_b("back_m_valid", m_valid, 1'b0);
    end
    // Level held high from an old result must not be taken as a new one.
    PM_DOUT_x = opv(32'h111, 9'h0);
    PM_DOUT_y = opv(32'h999, 9'h0);
    PM_OUT_VALID = 1'b1;
    load(32'h7, 32'h8, 32'h9, 32'hA, 32'h0, 32);
    chk_b("held_fire", PM_IN_VALID, 1'b1);
    repeat (3) @(negedge CLK);
    chk_b("held_ignored", m_valid, 1'b0);
    PM_OUT_VALID = 1'b0;
    @(negedge CLK);
    chk_b("held_drop", m_valid, 1'b0);
    pulse(opv(32'h222, 9'h0), opv(32'h333, 9'h0));
    chk_b("held_capture", m_valid, 1'b1);
    drain(outv(32'h222, 32'h0, 32'h333, 32'h0));
    // Reset partway through a frame discards it.
    base = fire_cnt;
    load(32'h77, 32'h78, 32'h79, 32'h7A, 32'hFFFFFFFF, 10);
    do_reset();
    chk_n("midrst_x_clear", PM_DIN_P_x, '0);
    chk_b("midrst_s_ready", s_ready, 1'b1);
    load(32'h42, 32'h43, 32'h44, 32'h45, 32'h0, 32);
    chk_b("midrst_fire", PM_IN_VALID, 1'b1);
    chk_n("midrst_x", PM_DIN_P_x, opv(32'h42, 9'h0));
    chk_n("midrst_y", PM_DIN_P_y, opv(32'h43, 9'h0));
    chk_n("midrst_key", PM_key, opv(32'h45, 9'h0));
    @(negedge CLK);
    chk_i("midrst_fire_count", fire_cnt - base, 1);
    do_reset();
    chk_b("rst_from_wait", busy, 1'b0);
`ifdef PM_ADAPTER_TIMEOUT_EN
    load(32'h1, 32'h2, 32'h3, 32'h5, 32'h0, 32);
    repeat (16) @(negedge CLK);
    chk_b("tmo_not_yet", m_valid, 1'b0);
    @(negedge CLK);
    chk_b("tmo_send", m_valid, 1'b1);
    chk_b("tmo_flag", timeout, 1'b1);
    drain('0);
    chk_b("tmo_held_load", timeout, 1'b1);
    load(32'h1, 32'h2, 32'h3, 32'h5, 32'h0, 32);
    chk_b("tmo_held_fire", timeout, 1'b1);
    @(negedge CLK);
    chk_b("tmo_cleared", timeout, 1'b0);
    pulse(opv(32'h5, 9'h0), opv(32'h6, 9'h0));
    drain(outv(32'h5, 32'h0, 32'h6, 32'h0));
`else
    load(32'h1, 32'h2, 32'h3, 32'h5, 32'h0, 32);
    repeat (40) @(negedge CLK);
    chk_b("no_tmo_wait", m_valid, 1'b0);
    chk_b("no_tmo_flag", timeout, 1'b0);
    pulse(opv(32'h5, 9'h0), opv(32'h6, 9'h0));
    drain(outv(32'h5, 32'h0, 32'h6, 32'h0));
`endif
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
